// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
//   pll_state_e   : sequencer FSM state (encoding is visible on the debug port)
//   cyc_cnt_width : width of the shared cycle counter for a given set of limits
package pll_seq_pkg;

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } pll_state_e;

    // One extra bit so the counter can hold the limit value itself (e.g. 4096).
    function automatic int unsigned cyc_cnt_width(input int unsigned timeout,
                                                  input int unsigned rst_cycles,
                                                  input int unsigned stagger);
        int unsigned m;
        m = timeout;
        if (rst_cycles > m) m = rst_cycles;
        if (stagger > m) m = stagger;
        return $clog2(m) + 1;
    endfunction

    localparam int unsigned CYC_CNT_W = cyc_cnt_width(4096, 16, 8);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit status input.
// Ports:
//   i_clk   : destination clock
//   i_clr_n : synchronous active-low clear of both flops
//   i_d     : asynchronous input
//   o_q     : synchronized output (2 cycles of latency)
module sync_2ff (
    input  logic i_clk,
    input  logic i_clr_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset and staggered domain-reset sequencer.
// Pulses the PLL reset, waits for a stable synchronized LOCKED, then releases the
// per-domain active-low resets one by one. Lock loss re-asserts everything and
// restarts the PLL.
// Ports:
//   i_clk          : reference clock (also the PLL input clock)
//   i_cpu_reset_n  : synchronous active-low board reset
//   i_pll_locked   : PLL LOCKED, asynchronous to i_clk
//   o_pll_rst      : PLL RST, active-high
//   o_dom_rst_n    : per-domain active-low resets, bit 0 released first
//   o_ready        : all domains released and lock held
//   o_relock_count : saturating count of lock losses after release started
//   o_state        : current FSM state, for debug
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS        = 3,
    parameter int unsigned PLL_RST_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE_CYCLES = 64,
    parameter int unsigned LOCK_TIMEOUT       = 4096,
    parameter int unsigned STAGGER_CYCLES     = 8,
    parameter int unsigned CNT_W              = 8
) (
    input  logic                   i_clk,
    input  logic                   i_cpu_reset_n,
    input  logic                   i_pll_locked,
    output logic                   o_pll_rst,
    output logic [NUM_DOMAINS-1:0] o_dom_rst_n,
    output logic                   o_ready,
    output logic [CNT_W-1:0]       o_relock_count,
    output logic [1:0]             o_state
);

    localparam int unsigned CW = cyc_cnt_width(LOCK_TIMEOUT, PLL_RST_CYCLES, STAGGER_CYCLES);

    localparam logic [CW-1:0]    RST_LAST   = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0]    STAG_LAST  = CW'(STAGGER_CYCLES - 1);
    localparam logic [CW-1:0]    TIMEOUT    = CW'(LOCK_TIMEOUT);
    localparam logic [CW-1:0]    STABLE     = CW'(LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0] RELOCK_MAX = '1;

    pll_state_e             r_state,  w_state_d;
    logic [CW-1:0]          r_cnt,    w_cnt_d;
    logic [CW-1:0]          r_stab,   w_stab_d;
    logic [NUM_DOMAINS-1:0] r_dom,    w_dom_d;
    logic [CNT_W-1:0]       r_relock, w_relock_d;
    logic                   r_pll_rst, w_pll_rst_d;
    logic                   r_ready,   w_ready_d;
    logic [NUM_DOMAINS:0]   w_shift;
    logic                   w_locked_s;
    logic                   w_sync_clr_n;

    // LOCKED means nothing while the PLL is held in reset, so the synchronizer is
    // kept clear then; stability is always measured from the PLL reset release.
    assign w_sync_clr_n = i_cpu_reset_n & (r_state != RESET_PLL);

    sync_2ff u_lock_sync (
        .i_clk   (i_clk),
        .i_clr_n (w_sync_clr_n),
        .i_d     (i_pll_locked),
        .o_q     (w_locked_s)
    );

    always_ff @(posedge i_clk) begin
        if (!i_cpu_reset_n) begin
            r_state   <= RESET_PLL;
            r_cnt     <= '0;
            r_stab    <= '0;
            r_dom     <= '0;
            r_relock  <= '0;
            r_pll_rst <= 1'b1;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_stab    <= w_stab_d;
            r_dom     <= w_dom_d;
            r_relock  <= w_relock_d;
            r_pll_rst <= w_pll_rst_d;
            r_ready   <= w_ready_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt + 1'b1;
        w_stab_d   = '0;
        w_dom_d    = r_dom;
        w_relock_d = r_relock;
        // Shift a one in from the bottom to release the next domain in index order.
        w_shift    = {r_dom, 1'b1};

        unique case (r_state)
            RESET_PLL: begin
                w_dom_d = '0;
                if (r_cnt == RST_LAST) begin
                    w_state_d = WAIT_LOCK;
                    w_cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                w_stab_d = w_locked_s ? (r_stab + 1'b1) : '0;
                // Stability is tested first so it wins a tie with the timeout.
                if (w_stab_d == STABLE) begin
                    w_state_d = RELEASE;
                    w_cnt_d   = '0;
                    w_dom_d   = NUM_DOMAINS'(1);
                end else if (w_cnt_d == TIMEOUT) begin
                    w_state_d = RESET_PLL;
                    w_cnt_d   = '0;
                end
            end
            RELEASE: begin
                if (!w_locked_s) begin
                    w_state_d = RESET_PLL;
                    w_cnt_d   = '0;
                    w_dom_d   = '0;
                    if (r_relock != RELOCK_MAX) w_relock_d = r_relock + 1'b1;
                end else if (&r_dom) begin
                    w_state_d = RUN;
                    w_cnt_d   = '0;
                end else if (r_cnt == STAG_LAST) begin
                    w_dom_d = w_shift[NUM_DOMAINS-1:0];
                    w_cnt_d = '0;
                end
            end
            RUN: begin
                w_cnt_d = '0;
                if (!w_locked_s) begin
                    w_state_d = RESET_PLL;
                    w_dom_d   = '0;
                    if (r_relock != RELOCK_MAX) w_relock_d = r_relock + 1'b1;
                end
            end
        endcase

        w_pll_rst_d = (w_state_d == RESET_PLL);
        w_ready_d   = (w_state_d == RUN);
    end

    assign o_pll_rst      = r_pll_rst;
    assign o_dom_rst_n    = r_dom;
    assign o_ready        = r_ready;
    assign o_relock_count = r_relock;
    assign o_state        = r_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: a timestamp-based model of the
// sequencing rules checked every cycle, plus hand-computed literal expectations.
module tb_pll_lock_sequencer;

    localparam int N_DOM   = 3;
    localparam int RST_CYC = 16;
    localparam int STABLE  = 64;
    localparam int TMO     = 4096;
    localparam int STAG    = 8;
    localparam int CW      = 8;
    localparam int PH_RST  = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_REL  = 2;
    localparam int PH_RUN  = 3;
    localparam int MASK    = 65535;

    logic             clk;
    logic             cpu_reset_n;
    logic             pll_locked;
    logic             pll_rst;
    logic [N_DOM-1:0] dom_rst_n;
    logic             ready;
    logic [CW-1:0]    relock_count;
    logic [1:0]       state;

    pll_lock_sequencer #(
        .NUM_DOMAINS        (N_DOM),
        .PLL_RST_CYCLES     (RST_CYC),
        .LOCK_STABLE_CYCLES (STABLE),
        .LOCK_TIMEOUT       (TMO),
        .STAGGER_CYCLES     (STAG),
        .CNT_W              (CW)
    ) dut (
        .i_clk          (clk),
        .i_cpu_reset_n  (cpu_reset_n),
        .i_pll_locked   (pll_locked),
        .o_pll_rst      (pll_rst),
        .o_dom_rst_n    (dom_rst_n),
        .o_ready        (ready),
        .o_relock_count (relock_count),
        .o_state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
            if (n_err >= 50) begin
                $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
                $finish;
            end
        end
    endtask

    // ---------------- model ----------------
    // Phase plus the cycle it started in; released bits follow from elapsed time.
    int  m_phase    = PH_RST;
    int  m_start    = 0;
    int  m_last_low = 0;
    int  m_relock   = 0;
    bit  m_ls;
    bit  lk_h  [0:MASK];
    bit  clr_h [0:MASK];

    always @(posedge clk) begin
        // Synchronized lock seen this cycle: raw sample from two edges back,
        // unless either of those edges cleared the synchronizer.
        m_ls = (cyc >= 2) && lk_h[(cyc - 2) & MASK] && !clr_h[(cyc - 2) & MASK]
               && !clr_h[(cyc - 1) & MASK];
        lk_h[cyc & MASK]  = pll_locked;
        clr_h[cyc & MASK] = !cpu_reset_n || (m_phase == PH_RST);
        if (!cpu_reset_n) begin
            m_phase  = PH_RST;
            m_start  = cyc + 1;
            m_relock = 0;
        end else begin
            case (m_phase)
                PH_RST: begin
                    if (cyc + 1 - m_start == RST_CYC) begin
                        m_phase    = PH_WAIT;
                        m_start    = cyc + 1;
                        m_last_low = cyc;
                    end
                end
                PH_WAIT: begin
                    if (!m_ls) m_last_low = cyc;
                    if (cyc - m_last_low >= STABLE) begin
                        m_phase = PH_REL;
                        m_start = cyc + 1;
                    end else if (cyc + 1 - m_start == TMO) begin
                        m_phase = PH_RST;
                        m_start = cyc + 1;
                    end
                end
                default: begin
                    if (!m_ls) begin
                        m_phase  = PH_RST;
                        m_start  = cyc + 1;
                        m_relock = (m_relock < 255) ? m_relock + 1 : 255;
                    end else if (m_phase == PH_REL && cyc - m_start >= (N_DOM - 1) * STAG) begin
                        m_phase = PH_RUN;
                        m_start = cyc + 1;
                    end
                end
            endcase
        end
        cyc++;
    end

    function automatic logic [N_DOM-1:0] exp_dom(input int ph, input int st, input int c);
        logic [N_DOM-1:0] v;
        v = '0;
        if (ph == PH_RUN) v = '1;
        else if (ph == PH_REL)
            for (int k = 0; k < N_DOM; k++) if (c - st >= k * STAG) v[k] = 1'b1;
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en)
            chk("cycle_model",
                {17'd0, pll_rst, dom_rst_n, ready, state, relock_count},
                {17'd0, (m_phase == PH_RST), exp_dom(m_phase, m_start, cyc),
                 (m_phase == PH_RUN), 2'(m_phase), 8'(m_relock)});
    end

    // ---------------- directed stimulus ----------------
    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_ready(input int bound);
        int k;
        k = 0;
        while (!ready && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", 32'(ready), 32'd1);
    endtask

    int c0, r, x, t, d, w, w2;

    initial begin
        cpu_reset_n = 1'b0;
        pll_locked  = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_vals", {pll_rst, dom_rst_n, ready, state, relock_count}, 15'h4000);

        // Power-up with lock already high.
        c0 = cyc;
        cpu_reset_n = 1'b1;
        goto(c0 + 15); chk("prst_hold", 32'(pll_rst), 32'd1);
        goto(c0 + 16); chk("prst_fall", 32'(pll_rst), 32'd0);
        goto(c0 + 81); chk("dom_pre", 32'(dom_rst_n), 32'd0);
        goto(c0 + 82); chk("dom_001", 32'(dom_rst_n), 32'd1);
        goto(c0 + 89); chk("dom_001_hold", 32'(dom_rst_n), 32'd1);
        goto(c0 + 90); chk("dom_011", 32'(dom_rst_n), 32'd3);
        goto(c0 + 98); chk("dom_111", 32'(dom_rst_n), 32'd7);
                       chk("ready_pre", 32'(ready), 32'd0);
        goto(c0 + 99); chk("ready_on", 32'(ready), 32'd1);
                       chk("relock_0", 32'(relock_count), 32'd0);

        // 10-cycle lock drop in RUN, then reset pulse during the re-release.
        r = c0 + 110;
        goto(r); pll_locked = 1'b0;
        goto(r + 2);  chk("loss_lat2", 32'(dom_rst_n), 32'd7);
        goto(r + 3);  chk("loss_dom", 32'(dom_rst_n), 32'd0);
                      chk("loss_prst", 32'(pll_rst), 32'd1);
                      chk("loss_relock", 32'(relock_count), 32'd1);
        goto(r + 10); pll_locked = 1'b1;
        goto(r + 84); chk("rerel_pre", 32'(dom_rst_n), 32'd0);
        goto(r + 85); chk("rerel_001", 32'(dom_rst_n), 32'd1);
        goto(r + 86); cpu_reset_n = 1'b0;
        goto(r + 87); chk("pulse_vals", {pll_rst, dom_rst_n, ready, state, relock_count}, 15'h4000);
        c0 = cyc;
        cpu_reset_n = 1'b1;

        // Lock drops on the edge where bit 1 would have released.
        goto(c0 + 87); pll_locked = 1'b0;
        goto(c0 + 89); chk("tie_dom_pre", 32'(dom_rst_n), 32'd1);
        goto(c0 + 90); chk("tie_dom", 32'(dom_rst_n), 32'd0);
                       chk("tie_relock", 32'(relock_count), 32'd1);
                       chk("tie_state", 32'(state), 32'd0);

        // Lock chatters low every 40 cycles, then holds.
        t = c0 + 95;
        goto(t); pll_locked = 1'b1;
        for (int i = 0; i < 5; i++) begin
            goto(t + 39); pll_locked = 1'b0;
            goto(t + 40); pll_locked = 1'b1;
            t += 40;
        end
        x = t - 1;
        goto(x + 66); chk("chat_pre", 32'(dom_rst_n), 32'd0);
                      chk("chat_wait", 32'(state), 32'd1);
        goto(x + 67); chk("chat_rel", 32'(dom_rst_n), 32'd1);

        // Saturation of relock_count.
        for (int i = 0; i < 300; i++) begin
            wait_ready(300);
            pll_locked = 1'b0;
            repeat (10) @(negedge clk);
            pll_locked = 1'b1;
        end
        chk("relock_sat", 32'(relock_count), 32'd255);

        // Lock never returns: timeout re-pulse, then a stability/timeout tie.
        wait_ready(300);
        d = cyc;
        pll_locked = 1'b0;
        goto(d + 3); chk("nolock_prst", 32'(pll_rst), 32'd1);
                     chk("nolock_sat", 32'(relock_count), 32'd255);
        w = d + 19;
        goto(w + 4095); chk("tmo_pre", 32'(pll_rst), 32'd0);
        goto(w + 4096); chk("tmo_prst", 32'(pll_rst), 32'd1);
        w2 = w + 4112;
        goto(w2 - 1); chk("tmo_hold", 32'(pll_rst), 32'd1);
        goto(w2);     chk("tmo_fall", 32'(pll_rst), 32'd0);
        goto(w2 + 4030); pll_locked = 1'b1;
        goto(w2 + 4095); chk("both_pre", 32'(state), 32'd1);
        goto(w2 + 4096); chk("both_state", 32'(state), 32'd2);
                         chk("both_dom", 32'(dom_rst_n), 32'd1);
        wait_ready(100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle %0d: got timeout, expected completion", cyc);
        $fatal(1);
    end

endmodule
